// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port RAM between the PC fetch path and the load/store path.
// Define ARB_STATS_EN to add the fetch_cnt / data_cnt / conflict_cnt statistics outputs.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_data,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_ren,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       fetch_cnt,
   output logic [15:0]       data_cnt,
   output logic [15:0]       conflict_cnt
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [1:0] T_FETCH  = 2'd0;
   localparam logic [1:0] T_LOAD   = 2'd1;
   localparam logic [1:0] T_STORE  = 2'd2;

   localparam logic G_FETCH = 1'b0;
   localparam logic G_DATA  = 1'b1;

   // MEM_LATENCY is limited to 1..15 so the last access cycle fits the 4-bit counter
   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              last_grant;
   logic [1:0]        acc_type;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic d_pend;
   logic grant_any;
   logic grant_data;

   // On a conflict the side that did not win last time gets the RAM
   always_comb begin
      d_pend     = d_read | d_write;
      grant_any  = i_req | d_pend;
      grant_data = d_pend & (~i_req | (last_grant == G_FETCH));
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         last_grant <= G_FETCH;
         acc_type   <= T_FETCH;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         i_data     <= '0;
         d_rdata    <= '0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  state      <= S_ACCESS;
                  cnt        <= 4'd0;
                  last_grant <= grant_data;
                  if (grant_data) begin
                     lat_addr  <= d_addr;
                     lat_wdata <= d_wdata;
                     acc_type  <= d_write ? T_STORE : T_LOAD;
                  end else begin
                     lat_addr  <= i_addr;
                     lat_wdata <= '0;
                     acc_type  <= T_FETCH;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt == LAST_CNT) begin
                  state   <= S_DONE;
                  cnt     <= 4'd0;
                  i_ready <= (acc_type == T_FETCH);
                  d_ready <= (acc_type != T_FETCH);
                  if (acc_type == T_FETCH) begin
                     i_data <= ram_rdata;
                  end
                  if (acc_type == T_LOAD) begin
                     d_rdata <= ram_rdata;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end
         endcase
      end
   end

   // Strobes decode only from registered state, so nothing combinational reaches the RAM from the requesters
   always_comb begin
      busy      = (state != S_IDLE);
      ram_addr  = lat_addr;
      ram_wdata = lat_wdata;
      ram_ren   = (state == S_ACCESS) && (acc_type != T_STORE);
      ram_wen   = (state == S_ACCESS) && (acc_type == T_STORE);
   end

`ifdef ARB_STATS_EN
   logic access_end;

   always_comb begin
      access_end = (state == S_ACCESS) && (cnt == LAST_CNT);
   end

   // Counters saturate instead of wrapping so long runs never read as small numbers
   always_ff @(posedge clk) begin
      if (nrst) begin
         fetch_cnt    <= 16'd0;
         data_cnt     <= 16'd0;
         conflict_cnt <= 16'd0;
      end else begin
         if (access_end && (acc_type == T_FETCH) && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (access_end && (acc_type != T_FETCH) && (data_cnt != 16'hFFFF)) begin
            data_cnt <= data_cnt + 16'd1;
         end
         if ((state == S_IDLE) && i_req && d_pend && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a transaction-level model predicts winner, strobes, ready pulses and captured data.
// Runs the default build (ARB_STATS_EN undefined).
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clk;
   logic        nrst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_ready;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram    [64];
   logic [31:0] refmem [64];
   logic        lastGrantData;
   logic [31:0] expIData;
   logic [31:0] expDRdata;

   mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_data(i_data),
      .i_ready(i_ready),
      .d_read(d_read),
      .d_write(d_write),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_rdata(d_rdata),
      .d_ready(d_ready),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_ren(ram_ren),
      .ram_wen(ram_wen),
      .ram_rdata(ram_rdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: asynchronous read, write on the rising edge while the write strobe is high
   assign ram_rdata = ram[ram_addr[7:2]];
   always @(posedge clk) begin
      if (ram_wen) ram[ram_addr[7:2]] <= ram_wdata;
   end

   task automatic applyStimulus(input logic rq, input logic rd, input logic wr,
                                input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
      i_req   = rq;
      d_read  = rd;
      d_write = wr;
      i_addr  = ia;
      d_addr  = da;
      d_wdata = wd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] randAddr();
      return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
   endfunction

   // One full request/grant/access/ready sequence, entered and left at a negedge inside an IDLE cycle
   task automatic runTransaction(input logic rq, input logic rd, input logic wr,
                                 input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
      logic        dataWins;
      logic        isStore;
      logic [31:0] expAddr;
      applyStimulus(rq, rd, wr, ia, da, wd);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_ren", 32'(ram_ren), 32'd0);
      checkOutput("idle_wen", 32'(ram_wen), 32'd0);
      if (!(rq | rd | wr)) begin
         @(negedge clk);
         return;
      end
      dataWins = (rd | wr) && (!rq || !lastGrantData);
      isStore  = dataWins && wr;
      expAddr  = dataWins ? da : ia;
      lastGrantData = dataWins;
      @(negedge clk);
      for (int k = 0; k < LAT; k++) begin
         applyStimulus(rq, rd, wr, randAddr(), randAddr(), $urandom);
         checkOutput("acc_busy", 32'(busy), 32'd1);
         checkOutput("acc_ren", 32'(ram_ren), 32'(!isStore));
         checkOutput("acc_wen", 32'(ram_wen), 32'(isStore));
         checkOutput("acc_addr", ram_addr, expAddr);
         if (isStore) checkOutput("acc_wdata", ram_wdata, wd);
         checkOutput("acc_iready", 32'(i_ready), 32'd0);
         checkOutput("acc_dready", 32'(d_ready), 32'd0);
         checkOutput("acc_idata", i_data, expIData);
         checkOutput("acc_drdata", d_rdata, expDRdata);
         @(negedge clk);
      end
      if (!dataWins)     expIData  = refmem[ia[7:2]];
      else if (!isStore) expDRdata = refmem[da[7:2]];
      else               refmem[da[7:2]] = wd;
      checkOutput("done_iready", 32'(i_ready), 32'(!dataWins));
      checkOutput("done_dready", 32'(d_ready), 32'(dataWins));
      checkOutput("done_idata", i_data, expIData);
      checkOutput("done_drdata", d_rdata, expDRdata);
      checkOutput("done_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
      checkOutput("done_busy", 32'(busy), 32'd1);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), randAddr(), randAddr(), $urandom);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram[i]    = $urandom;
         refmem[i] = ram[i];
      end
      ram[4]    = 32'h00500093;
      refmem[4] = 32'h00500093;
      lastGrantData = 1'b0;
      expIData  = 32'd0;
      expDRdata = 32'd0;

      // Reset with every request high: reset must dominate
      nrst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h40, 32'h12345678);
      repeat (3) @(negedge clk);
      checkOutput("rst_idata", i_data, 32'd0);
      checkOutput("rst_drdata", d_rdata, 32'd0);
      checkOutput("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
      checkOutput("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
      checkOutput("rst_ramaddr", ram_addr, 32'd0);
      checkOutput("rst_ramwdata", ram_wdata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      nrst = 1'b0;

      // First conflict after reset goes to DATA, FETCH follows at the next IDLE
      runTransaction(1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 32'd0);
      runTransaction(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 32'd0);
      checkOutput("first_fetch", i_data, 32'h00500093);

      // Read+write together is a store; d_rdata keeps the earlier load
      runTransaction(1'b0, 1'b1, 1'b1, 32'h10, 32'h44, 32'hDEADBEEF);
      runTransaction(1'b0, 1'b1, 1'b0, 32'h10, 32'h44, 32'd0);
      checkOutput("store_readback", d_rdata, 32'hDEADBEEF);

      for (int n = 0; n < 60; n++) begin
         runTransaction(1'($urandom), 1'($urandom), 1'($urandom), randAddr(), randAddr(), $urandom);
      end

      // Reset in the second ACCESS cycle of a load abandons it silently
      runTransaction(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h48, 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_rst_ren", 32'(ram_ren), 32'd1);
      nrst = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
      checkOutput("mid_rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
      checkOutput("mid_rst_dready", 32'(d_ready), 32'd0);
      checkOutput("mid_rst_drdata", d_rdata, 32'd0);
      checkOutput("mid_rst_idata", i_data, 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      nrst = 1'b0;
      lastGrantData = 1'b0;
      expIData  = 32'd0;
      expDRdata = 32'd0;

      runTransaction(1'b1, 1'b1, 1'b0, 32'h10, 32'h4C, 32'd0);
      runTransaction(1'b1, 1'b1, 1'b0, 32'h14, 32'h50, 32'd0);
      runTransaction(1'b1, 1'b1, 1'b1, 32'h18, 32'h54, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port instruction/data RAM between the PC fetch path and the load/store path.
- Grants one access at a time and holds the RAM strobes for a fixed latency.
- Captures the read data and returns a one-cycle ready pulse to the winner: i_ready enables the PC, d_ready releases the writeback of the load.
- Sits between pc / control / alu and ram_wrapper.

Parameters:
- ADDR_W, 32, address width of both request ports and the RAM port
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles the RAM strobe is held before ram_rdata is valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  synchronous reset, active-high (name kept per codebase convention; 1 = reset)
- i_req  in  1  fetch request, level
- i_addr  in  ADDR_W  fetch address (pc)
- i_data  out  DATA_W  last fetched instruction, registered
- i_ready  out  1  one-cycle pulse: i_data valid, PC may advance
- d_read  in  1  load request, level
- d_write  in  1  store request, level
- d_addr  in  ADDR_W  data address (aluOut)
- d_wdata  in  DATA_W  store data (regData2)
- d_rdata  out  DATA_W  last loaded word, registered
- d_ready  out  1  one-cycle pulse: load data valid or store committed
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (nrst=1 at edge):
  - state=IDLE; all outputs 0, including i_data and d_rdata; cnt=0; last_grant=FETCH.
  - Applies mid-access: strobes drop on that edge, no ready pulse is issued, and the in-flight access is abandoned.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples requests; d_pend = d_read | d_write.
  - Only i_req: grant FETCH.
  - Only d_pend: grant DATA.
  - Both: grant the side not equal to last_grant (round-robin). After reset the first conflict therefore goes to DATA.
  - Neither: stay in IDLE, strobes low.
- On grant (IDLE edge):
  - Latch addr, wdata and type (FETCH / LOAD / STORE) into internal registers. Request inputs are ignored until the next IDLE.
  - d_read and d_write both high: STORE wins and d_read is ignored.
  - Update last_grant; cnt=0; go to ACCESS.
- ACCESS:
  - ram_addr/ram_wdata come from the latched registers.
  - ram_ren=1 for FETCH and LOAD; ram_wen=1 for STORE. The strobe is held for exactly MEM_LATENCY cycles.
  - cnt increments each cycle. On the edge where cnt==MEM_LATENCY-1:
    - FETCH: capture ram_rdata into i_data.
    - LOAD: capture ram_rdata into d_rdata.
    - STORE: no capture.
    - Go to DONE.
- DONE (1 cycle):
  - Strobes low.
  - i_ready=1 if FETCH, d_ready=1 if LOAD or STORE; never both.
  - Requests are ignored.
  - Next state is IDLE.
- Handshake contract:
  - The requester holds req and its operands until its ready pulse.
  - It deasserts req in the ready cycle, or keeps it high to request a back-to-back access.
- Latency: request seen in IDLE to ready pulse = MEM_LATENCY+1 cycles. Minimum issue interval = MEM_LATENCY+2 cycles.
- Captured data is unchanged by other-side accesses and by stores (d_rdata keeps its last load).
- i_ready and d_ready are registered, with no combinational path from any input.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs fetch_cnt[15:0], data_cnt[15:0], conflict_cnt[15:0].
  - fetch_cnt and data_cnt increment on each i_ready / d_ready pulse.
  - conflict_cnt increments on each IDLE cycle with both sides requesting.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan (MEM_LATENCY=2 unless noted):
- Reset, then i_req=1, i_addr=0x10, ram_rdata=0x00500093 -> ram_ren high for 2 cycles with ram_addr=0x10; i_ready pulses on cycle 3; i_data=0x00500093; d_ready stays 0.
- i_req and d_read both high after reset, d_addr=0x40 -> DATA granted first (ram_addr=0x40); FETCH is granted at the next IDLE; d_ready precedes i_ready by 4 cycles.
- d_write=1, d_read=1, d_addr=0x44, d_wdata=0xDEADBEEF -> ram_wen high for 2 cycles with ram_wdata=0xDEADBEEF; ram_ren stays 0; d_ready pulses; d_rdata unchanged.
- Change i_addr from 0x10 to 0x20 during ACCESS -> ram_addr stays 0x10 until DONE.
- Assert nrst during the second ACCESS cycle of a load -> strobes 0 on the next cycle; no d_ready; d_rdata=0; busy=0.
- MEM_LATENCY=1 with i_req held high continuously -> i_ready pulses every 3 cycles. With ARB_STATS_EN defined, fetch_cnt=4 after 4 pulses.
